// File: rtl/inst_fetch_buffer_if.sv
// Fetch-stage bus bundle: PC stage controls, instruction-memory request/response
// channel and the decode-side valid/ready handshake.
interface inst_fetch_buffer_if;
  logic [31:0] pc;
  logic        ce;
  logic        flush;
  logic        pc_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  // Environment side: PC stage, instruction memory and ID stage.
  modport master (
    output pc, ce, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  pc_stall, imem_req, imem_addr, id_valid, id_pc, id_inst
  );

  // Fetch buffer side.
  modport slave (
    input  pc, ce, flush, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output pc_stall, imem_req, imem_addr, id_valid, id_pc, id_inst
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: issues one memory request per PC, tags returned
// words with their PC in an in-order circular buffer and presents them to
// decode. On a flush all entries are freed and responses still owed for
// wrong-path requests are counted in r_drop and discarded on arrival.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  inst_fetch_buffer_if.slave   bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // Buffer storage.
  logic [31:0]      r_pc     [DEPTH];
  logic [31:0]      r_inst   [DEPTH];
  logic [DEPTH-1:0] r_filled;

  // Pointers (wrap naturally since DEPTH is a power of two) and counters.
  logic [PW-1:0] r_alloc;
  logic [PW-1:0] r_fill;
  logic [PW-1:0] r_head;
  logic [CW-1:0] r_used;
  logic [CW-1:0] r_unfilled;
  logic [CW-1:0] r_drop;

  logic          w_req;
  logic          w_accept;
  logic          w_drop_rsp;
  logic          w_fill;
  logic          w_valid;
  logic          w_pop;
  logic          w_stall;
  logic [31:0]   w_id_pc;
  logic [31:0]   w_id_inst;
  logic [CW-1:0] w_used_nxt;
  logic [CW-1:0] w_unfilled_nxt;
  logic [CW-1:0] w_drop_nxt;

  // Issue, response classification, delivery and next-state counter values.
  always_comb begin
    w_req          = 1'b0;
    w_accept       = 1'b0;
    w_drop_rsp     = 1'b0;
    w_fill         = 1'b0;
    w_valid        = 1'b0;
    w_pop          = 1'b0;
    w_stall        = 1'b0;
    w_id_pc        = 32'h0000_0000;
    w_id_inst      = 32'h0000_0000;
    w_used_nxt     = r_used;
    w_unfilled_nxt = r_unfilled;
    w_drop_nxt     = r_drop;

    // Outstanding requests (live plus to-be-dropped) are bounded by DEPTH so
    // r_drop can never overflow; the reset term keeps the bus quiet in reset.
    w_req = i_rst_n & bus.ce & ~bus.flush
          & ({1'b0, r_used} < DEPTH_W)
          & (({1'b0, r_unfilled} + {1'b0, r_drop}) < DEPTH_W);
    w_accept = w_req & bus.imem_gnt;
    w_stall  = bus.ce & ~bus.flush & ~w_accept;

    // A response with nothing owed is a protocol error and is ignored.
    w_drop_rsp = bus.imem_rvalid & (r_drop != {CW{1'b0}});
    w_fill     = bus.imem_rvalid & (r_drop == {CW{1'b0}}) & (r_unfilled != {CW{1'b0}});

    w_valid = ~bus.flush & (r_used != {CW{1'b0}}) & r_filled[r_head];
    w_pop   = w_valid & bus.id_ready;

    if (w_valid) begin
      w_id_pc   = r_pc[r_head];
      w_id_inst = r_inst[r_head];
    end else begin
      w_id_pc   = 32'h0000_0000;
      w_id_inst = 32'h0000_0000;
    end

    if (bus.flush) begin
      // Every unfilled entry becomes a response to discard; one arriving in
      // this same cycle is already consumed here.
      w_used_nxt     = {CW{1'b0}};
      w_unfilled_nxt = {CW{1'b0}};
      if (bus.imem_rvalid && ((r_drop != {CW{1'b0}}) || (r_unfilled != {CW{1'b0}}))) begin
        w_drop_nxt = r_drop + r_unfilled - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        w_drop_nxt = r_drop + r_unfilled;
      end
    end else begin
      w_used_nxt     = r_used + CW'(w_accept) - CW'(w_pop);
      w_unfilled_nxt = r_unfilled + CW'(w_accept) - CW'(w_fill);
      w_drop_nxt     = r_drop - CW'(w_drop_rsp);
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = {bus.pc[31:2], 2'b00};
  assign bus.pc_stall  = w_stall;
  assign bus.id_valid  = w_valid;
  assign bus.id_pc     = w_id_pc;
  assign bus.id_inst   = w_id_inst;

  // Occupancy counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_used     <= {CW{1'b0}};
      r_unfilled <= {CW{1'b0}};
      r_drop     <= {CW{1'b0}};
    end else begin
      r_used     <= w_used_nxt;
      r_unfilled <= w_unfilled_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  // Ring pointers; a flush collapses head and fill onto the allocation point.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alloc <= {PW{1'b0}};
      r_fill  <= {PW{1'b0}};
      r_head  <= {PW{1'b0}};
    end else if (bus.flush) begin
      r_fill <= r_alloc;
      r_head <= r_alloc;
    end else begin
      if (w_accept) begin
        r_alloc <= r_alloc + PW'(1);
      end
      if (w_fill) begin
        r_fill <= r_fill + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
    end
  end

  // Entry storage: allocate with the PC, fill with the returned word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filled <= {DEPTH{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]   <= 32'h0000_0000;
        r_inst[k] <= 32'h0000_0000;
      end
    end else if (bus.flush) begin
      r_filled <= {DEPTH{1'b0}};
    end else begin
      if (w_accept) begin
        r_pc[r_alloc]     <= bus.pc;
        r_filled[r_alloc] <= 1'b0;
      end
      if (w_fill) begin
        r_inst[r_fill]   <= bus.imem_rdata;
        r_filled[r_fill] <= 1'b1;
      end
    end
  end

endmodule
